// File: rtl/crossbar_master_port.sv
// crossbar_master_port: master-side crossbar port; routes single-beat
// read/write requests to one of 2^SLAVE_BITS slaves with an ack timeout.
//
// Ports:
//   clock, reset (async, active-low)
//   req_m, cmd_m, addr_m, wdata_m   master request (sampled in IDLE)
//   ack_m, err_m, rdata_m, busy_m   master completion / status
//   req_s, cmd_s, addr_s, wdata_s   per-slave request bundles (packed)
//   ack_s, rdata_s                  per-slave responses (packed)
module crossbar_master_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int SLAVE_BITS = 1,
   parameter int TIMEOUT    = 15,
   localparam int NUM_SLAVES = 2 ** SLAVE_BITS
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             req_m,
   input  logic                             cmd_m,
   input  logic [ADDR_WIDTH-1:0]            addr_m,
   input  logic [DATA_WIDTH-1:0]            wdata_m,
   output logic                             ack_m,
   output logic                             err_m,
   output logic [DATA_WIDTH-1:0]            rdata_m,
   output logic                             busy_m,
   output logic [NUM_SLAVES-1:0]            req_s,
   output logic [NUM_SLAVES-1:0]            cmd_s,
   output logic [NUM_SLAVES*ADDR_WIDTH-1:0] addr_s,
   output logic [NUM_SLAVES*DATA_WIDTH-1:0] wdata_s,
   input  logic [NUM_SLAVES-1:0]            ack_s,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] rdata_s
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int CW =
      (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ?
                       $clog2(TIMEOUT + 1) : 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [1:0]            state;
   logic                  cmd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [SLAVE_BITS-1:0] sel_q;
   logic [CW-1:0]         cnt_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  ack_sel;
   logic [DATA_WIDTH-1:0] rdata_sel;
   logic                  to_hit;

   // Only the latched target's response is ever looked at.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SLAVE_BITS'(i)) begin
            ack_sel   = ack_s[i];
            rdata_sel = rdata_s[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cmd_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_m) begin
                  cmd_q   <= cmd_m;
                  addr_q  <= addr_m;
                  wdata_q <= wdata_m;
                  sel_q   <= addr_m[ADDR_WIDTH-1 -: SLAVE_BITS];
                  cnt_q   <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               // An ack on the last allowed cycle beats the timeout.
               if (ack_sel) begin
                  if (!cmd_q) rdata_q <= rdata_sel;
                  err_q <= 1'b0;
                  state <= RESP;
               end else if (to_hit) begin
                  if (!cmd_q) rdata_q <= '0;
                  err_q <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore outputs: decoded from state and latched registers only.
   always_comb begin
      req_s   = '0;
      cmd_s   = '0;
      addr_s  = '0;
      wdata_s = '0;
      if (state == REQ) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SLAVE_BITS'(i)) begin
               req_s[i] = 1'b1;
               cmd_s[i] = cmd_q;
               addr_s[i*ADDR_WIDTH +: ADDR_WIDTH]  = addr_q;
               wdata_s[i*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
            end
         end
      end
   end

   assign busy_m  = (state != IDLE);
   assign ack_m   = (state == RESP);
   assign err_m   = (state == RESP) && err_q;
   assign rdata_m = rdata_q;

endmodule

// File: tb/tb_crossbar_master_port.sv
// tb_crossbar_master_port: randomized self-checking bench for
// crossbar_master_port (4 slaves, 6-bit address, timeout of 4).
module tb_crossbar_master_port;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int SB = 2;
   localparam int TO = 4;
   localparam int NS = 4;

   logic             clock;
   logic             reset;
   logic             req_m;
   logic             cmd_m;
   logic [AW-1:0]    addr_m;
   logic [DW-1:0]    wdata_m;
   logic             ack_m;
   logic             err_m;
   logic [DW-1:0]    rdata_m;
   logic             busy_m;
   logic [NS-1:0]    req_s;
   logic [NS-1:0]    cmd_s;
   logic [NS*AW-1:0] addr_s;
   logic [NS*DW-1:0] wdata_s;
   logic [NS-1:0]    ack_s;
   logic [NS*DW-1:0] rdata_s;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] rdata_exp = '0;

   crossbar_master_port #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .SLAVE_BITS(SB),
      .TIMEOUT(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req_m(req_m),
      .cmd_m(cmd_m),
      .addr_m(addr_m),
      .wdata_m(wdata_m),
      .ack_m(ack_m),
      .err_m(err_m),
      .rdata_m(rdata_m),
      .busy_m(busy_m),
      .req_s(req_s),
      .cmd_s(cmd_s),
      .addr_s(addr_s),
      .wdata_s(wdata_s),
      .ack_s(ack_s),
      .rdata_s(rdata_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " req_s"}, 128'(req_s), 128'(0));
      chk({tag, " cmd_s"}, 128'(cmd_s), 128'(0));
      chk({tag, " addr_s"}, 128'(addr_s), 128'(0));
      chk({tag, " wdata_s"}, 128'(wdata_s), 128'(0));
   endtask

   // One transaction, starting and ending at a negedge in IDLE.
   // ack_at: REQ cycle (1-based) on which the target acks;
   // beyond TO means the slave never acks.
   task automatic txn(input logic [1:0] sel, input bit cmd,
                      input logic [DW-1:0] wd, input int ack_at,
                      input logic [DW-1:0] rd, input bit do_rst);
      logic [AW-1:0]    addr;
      logic [NS-1:0]    e_req;
      logic [NS-1:0]    e_cmd;
      logic [NS*AW-1:0] e_addr;
      logic [NS*DW-1:0] e_wd;
      logic [NS-1:0]    wrong;
      bit               acked;
      addr = {sel, 4'($urandom)};
      e_req  = NS'(1) << sel;
      e_cmd  = NS'(cmd) << sel;
      e_addr = (NS*AW)'(addr) << (int'(sel) * AW);
      e_wd   = (NS*DW)'(wd) << (int'(sel) * DW);
      req_m   = 1'b1;
      cmd_m   = cmd;
      addr_m  = addr;
      wdata_m = wd;
      @(negedge clock);
      // Scramble master inputs: the latched request must not change.
      req_m   = 1'b0;
      cmd_m   = 1'($urandom);
      addr_m  = AW'($urandom);
      wdata_m = $urandom;
      acked   = 1'b0;
      for (int c = 1; c <= TO; c++) begin
         chk("req_s", 128'(req_s), 128'(e_req));
         chk("cmd_s", 128'(cmd_s), 128'(e_cmd));
         chk("addr_s", 128'(addr_s), 128'(e_addr));
         chk("wdata_s", wdata_s, e_wd);
         chk("busy_req", 128'(busy_m), 128'(1));
         chk("ack_in_req", 128'({ack_m, err_m}), 128'(0));
         chk("rdata_hold", 128'(rdata_m), 128'(rdata_exp));
         if (do_rst && c == 2) begin
            #2 reset = 1'b0;
            #1;
            chk_quiet("rst");
            chk("rst_busy", 128'(busy_m), 128'(0));
            chk("rst_ack", 128'({ack_m, err_m}), 128'(0));
            chk("rst_rdata", 128'(rdata_m), 128'(0));
            rdata_exp = '0;
            ack_s   = '0;
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            chk("post_rst_ack", 128'(ack_m), 128'(0));
            chk("post_rst_busy", 128'(busy_m), 128'(0));
            return;
         end
         wrong = NS'($urandom) & ~e_req;
         rdata_s = {$urandom, $urandom, $urandom, $urandom};
         if (c == ack_at) begin
            wrong = wrong | e_req;
            rdata_s[int'(sel)*DW +: DW] = rd;
         end
         ack_s = wrong;
         @(negedge clock);
         if (c == ack_at) begin
            acked = 1'b1;
            break;
         end
      end
      if (!cmd) rdata_exp = acked ? rd : '0;
      chk("ack_m", 128'(ack_m), 128'(1));
      chk("err_m", 128'(err_m), 128'(!acked));
      chk("busy_resp", 128'(busy_m), 128'(1));
      chk("rdata_m", 128'(rdata_m), 128'(rdata_exp));
      chk_quiet("resp");
      ack_s = NS'($urandom);
      @(negedge clock);
      chk("idle_ack", 128'({ack_m, err_m}), 128'(0));
      chk("idle_busy", 128'(busy_m), 128'(0));
      chk("idle_rdata", 128'(rdata_m), 128'(rdata_exp));
      chk_quiet("idle");
      ack_s = '0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         ack_s   = NS'($urandom);
         rdata_s = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clock);
         chk("gap_busy", 128'(busy_m), 128'(0));
         chk("gap_ack", 128'(ack_m), 128'(0));
         chk("gap_req", 128'(req_s), 128'(0));
      end
      ack_s = '0;
   endtask

   initial begin
      reset   = 1'b0;
      req_m   = 1'b0;
      cmd_m   = 1'b0;
      addr_m  = '0;
      wdata_m = '0;
      ack_s   = '0;
      rdata_s = '0;
      repeat (2) @(negedge clock);
      chk_quiet("reset");
      chk("reset_ack", 128'({ack_m, err_m}), 128'(0));
      chk("reset_busy", 128'(busy_m), 128'(0));
      chk("reset_rdata", 128'(rdata_m), 128'(0));
      reset = 1'b1;
      @(negedge clock);

      txn(2'd0, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b0);
      txn(2'd1, 1'b1, 32'h12345678, 1, 32'hFFFFFFFF, 1'b0);
      txn(2'd2, 1'b0, 32'h0, TO + 1, 32'h55AA55AA, 1'b0);
      txn(2'd1, 1'b0, 32'h0, TO, 32'hCAFEF00D, 1'b0);
      txn(2'd3, 1'b1, 32'hA5A5A5A5, TO + 1, 32'h0, 1'b0);
      txn(2'd1, 1'b0, 32'h0, 1, 32'h0BADCAFE, 1'b1);
      txn(2'd2, 1'b0, 32'h0, 1, 32'h13579BDF, 1'b0);
      txn(2'd3, 1'b0, 32'h0, 1, 32'h11111111, 1'b0);
      txn(2'd0, 1'b1, 32'h22222222, 1, 32'h0, 1'b0);
      txn(2'd2, 1'b0, 32'h0, 1, 32'h33333333, 1'b0);

      for (int k = 0; k < 60; k++) begin
         txn(2'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(1, TO + 2)), $urandom,
             ($urandom_range(0, 19) == 0));
         if ($urandom_range(0, 3) == 0)
            idle_cycles(int'($urandom_range(1, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
